// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry valid/ready skid buffer between pipeline stages.
// in_ready is decoded from state alone, so downstream stalls never reach the
// upstream stage combinationally. Flush discards every held beat in one edge.
// All state updates on the falling edge of clk; reset is asynchronous, active-low.
// Optional feature: define PIPE_STALL_CNT_EN to add the saturating stall_count port.
module pipe_skid_stage #(
  parameter int unsigned N = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] DataInput,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] DataOutput
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]  stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;
  logic         push;
  logic         pop;
  logic         load_main_in;
  logic         load_main_skid;
  logic         load_skid;

  assign out_valid  = (state != EMPTY);
  assign in_ready   = (state != FULL);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign DataOutput = main_q;

  // State register; flush and reset both return to EMPTY.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and register-load decode; Flush overrides every other event.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_main_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    if (Flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Payload registers; not cleared on pop so DataOutput holds its last value.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (Flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= DataInput;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= DataInput;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating count of edges where a valid beat was refused downstream.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (Flush) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != '1)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and randomized checks of pipe_skid_stage against
// a FIFO-queue reference model. Optional PIPE_STALL_CNT_EN checks stall_count.
module tb_pipe_skid_stage;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         Flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] DataInput;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] DataOutput;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0]  stall_count;
`endif

  pipe_skid_stage #(.N(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Flush      (Flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .DataInput  (DataInput),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .DataOutput (DataOutput)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered queue of held beats, last visible payload, stall count.
  logic [W-1:0] q[$];
  logic [W-1:0] exp_out;
  int unsigned  exp_stall;
  logic         m_push;
  logic         m_pop;

  int unsigned  n_cmp;
  int unsigned  n_err;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_out   = '0;
    exp_stall = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, W'(out_valid), W'(q.size() != 0));
    check({tag, ".in_ready"},  W'(in_ready),  W'(q.size() < 2));
    check({tag, ".data"},      DataOutput,    exp_out);
`ifdef PIPE_STALL_CNT_EN
    check({tag, ".stall"},     W'(stall_count), W'(exp_stall));
`endif
  endtask

  // One falling-edge cycle: drive inputs, advance model, check #1 after the edge.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                      input logic fl, input string tag);
    in_valid  = iv;
    DataInput = d;
    out_ready = ordy;
    Flush     = fl;
    m_push = iv && (q.size() < 2);
    m_pop  = (q.size() != 0) && ordy;
    @(negedge clk);
    if (fl) begin
      q.delete();
      exp_out   = '0;
      exp_stall = 0;
    end else begin
      if ((q.size() != 0) && !ordy && (exp_stall < 32'hFFFF)) exp_stall++;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(d);
      if (q.size() != 0) exp_out = q[0];
    end
    #1;
    check_all(tag);
  endtask

  logic         cur_v;
  logic [W-1:0] cur_d;
  logic         ordy_r;
  logic         fl_r;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset     = 1'b0;
    Flush     = 1'b0;
    in_valid  = 1'b0;
    DataInput = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b1;

    step(1'b0, 32'h0, 1'b0, 1'b0, "idle");

    // Streaming at full rate.
    step(1'b1, 32'h1, 1'b1, 1'b0, "stream1");
    step(1'b1, 32'h2, 1'b1, 1'b0, "stream2");
    step(1'b1, 32'h3, 1'b1, 1'b0, "stream3");
    step(1'b0, 32'h0, 1'b1, 1'b0, "drain");

    // Back-pressure fills to FULL; 0xC waits upstream, then order is preserved.
    step(1'b1, 32'hA, 1'b0, 1'b0, "bp_a");
    step(1'b1, 32'hB, 1'b0, 1'b0, "bp_b");
    check("bp_full_in_ready", W'(in_ready), W'(0));
    step(1'b1, 32'hC, 1'b0, 1'b0, "bp_c_held");
    step(1'b1, 32'hC, 1'b1, 1'b0, "bp_pop_a");
    check("bp_out_b", DataOutput, 32'hB);
    step(1'b1, 32'hC, 1'b1, 1'b0, "bp_pop_b");
    check("bp_out_c", DataOutput, 32'hC);
    step(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain");

    // Flush while FULL with a concurrent offer of 0xD.
    step(1'b1, 32'h11, 1'b0, 1'b0, "fl_fill1");
    step(1'b1, 32'h22, 1'b0, 1'b0, "fl_fill2");
    step(1'b1, 32'hD, 1'b1, 1'b1, "flush_full");
    check("flush_data_zero", DataOutput, 32'h0);

    // Asynchronous reset between edges while holding one beat.
    step(1'b1, 32'h55, 1'b0, 1'b0, "one_55");
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    reset = 1'b1;

    // Randomized traffic honouring the upstream hold-until-push rule.
    cur_v = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!cur_v) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_d = $urandom;
      end
      ordy_r = ($urandom_range(0, 3) != 0);
      if (i % 500 < 100) ordy_r = ($urandom_range(0, 3) == 0);
      fl_r = ($urandom_range(0, 40) == 0);
      step(cur_v, cur_d, ordy_r, fl_r, "rand");
      if (m_push) cur_v = 1'b0;
    end

`ifdef PIPE_STALL_CNT_EN
    step(1'b1, 32'h77, 1'b0, 1'b0, "sat_load");
    for (int i = 0; i < 70000; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, "sat");
    end
    check("sat_value", W'(stall_count), W'(16'hFFFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
